// File: rtl/irq_sync_ctrl.sv
// -----------------------------------------------------------------------------
// irq_sync_ctrl
//
// Multi-channel interrupt input conditioner feeding the CSR interrupt path
// (mip/mie handling). Each of NUM_IRQ asynchronous lines is:
//   1. synchronised through a SYNC_DEPTH-deep flop chain (minimum 2 stages),
//   2. normalised to active-high using polarity_i,
//   3. optionally glitch-filtered (FILTER_LEN consecutive stable cycles),
//   4. latched as a rising edge into a pending bit (edge mode) or passed
//      through as a level (level mode).
// A registered OR of the masked pending bits is driven out as irq_o.
//
// Build option:
//   IRQ_SYNC_FILTER_EN  defined   -> per-channel counter filter, FILTER_LEN
//                                    honoured.
//                       undefined -> no counters, filter register simply
//                                    follows the normalised line every cycle
//                                    (behaves like FILTER_LEN = 1).
//
// Parameters:
//   NUM_IRQ        number of interrupt channels (>= 1)
//   SYNC_DEPTH     synchroniser flops per channel (values < 2 act as 2)
//   DEFAULT_LEVEL  bit 0 is the reset value of every synchroniser flop
//   FILTER_LEN     stable cycles needed before the filtered value changes
//
// Ports:
//   aclk        in   1        clock, single clock domain
//   areset      in   1        synchronous active-high reset, highest priority
//   irq_i       in   NUM_IRQ  raw asynchronous interrupt lines
//   polarity_i  in   NUM_IRQ  1 = active-low, 0 = active-high (quasi-static)
//   mode_i      in   NUM_IRQ  1 = edge (latched), 0 = level
//   mask_i      in   NUM_IRQ  per-channel enable towards irq_o
//   clr_i       in   NUM_IRQ  write-1-to-clear pulse for edge-mode pending
//   sync_o      out  NUM_IRQ  last synchroniser stage, raw polarity
//   pending_o   out  NUM_IRQ  pending register
//   irq_o       out  1        registered OR of (pending_o & mask_i)
// -----------------------------------------------------------------------------
module irq_sync_ctrl #(
  parameter int NUM_IRQ       = 8,
  parameter int SYNC_DEPTH    = 2,
  parameter int DEFAULT_LEVEL = 0,
  parameter int FILTER_LEN    = 3
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] polarity_i,
  input  logic [NUM_IRQ-1:0] mode_i,
  input  logic [NUM_IRQ-1:0] mask_i,
  input  logic [NUM_IRQ-1:0] clr_i,
  output logic [NUM_IRQ-1:0] sync_o,
  output logic [NUM_IRQ-1:0] pending_o,
  output logic               irq_o
);

  // ---------------------------------------------------------------------------
  // Derived configuration
  // ---------------------------------------------------------------------------
  // A single-flop chain is not a synchroniser; clamp to two stages.
  localparam int SYNC_STAGES = (SYNC_DEPTH < 2) ? 2 : SYNC_DEPTH;

  localparam logic RST_LEVEL = 1'(DEFAULT_LEVEL & 1);

`ifdef IRQ_SYNC_FILTER_EN
  localparam bit FILTER_BUILD = 1'b1;
`else
  localparam bit FILTER_BUILD = 1'b0;
`endif

  // Effective filter length. A length of 1 means "copy every cycle", which
  // needs no counter at all, so the generate below drops the counters in
  // that case (and always when the filter is compiled out).
  localparam int FILTER_CYCLES = !FILTER_BUILD      ? 1 :
                                 (FILTER_LEN < 1)   ? 1 : FILTER_LEN;

  // ---------------------------------------------------------------------------
  // Synchroniser chain: stage 0 captures the raw lines, the last stage is
  // the first value considered metastability-safe.
  // ---------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] sync_reg [SYNC_STAGES];

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= {NUM_IRQ{RST_LEVEL}};
      end
    end else begin
      sync_reg[0] <= irq_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  logic [NUM_IRQ-1:0] sync_last;
  assign sync_last = sync_reg[SYNC_STAGES-1];

  // Normalised request: 1 means "asserted" regardless of line polarity.
  logic [NUM_IRQ-1:0] asserted;
  assign asserted = sync_last ^ polarity_i;

  // ---------------------------------------------------------------------------
  // Glitch filter. filt_reg only moves once the normalised line has disagreed
  // with it for FILTER_CYCLES consecutive cycles; any agreement in between
  // restarts the count.
  // ---------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] filt_reg;
  logic [NUM_IRQ-1:0] filt_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_ch
      if (FILTER_CYCLES > 1) begin : g_filt
        localparam int             CNT_W    = $clog2(FILTER_CYCLES);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] cnt_next;
        logic             filt_bit_next;

        always_comb begin
          cnt_next      = cnt_reg;
          filt_bit_next = filt_reg[gi];
          if (asserted[gi] == filt_reg[gi]) begin
            cnt_next = '0;
          end else if (cnt_reg == CNT_LAST) begin
            filt_bit_next = asserted[gi];
            cnt_next      = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end

        always_ff @(posedge aclk) begin
          if (areset) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_next;
          end
        end

        assign filt_next[gi] = filt_bit_next;
      end else begin : g_nofilt
        assign filt_next[gi] = asserted[gi];
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Edge detection, pending register and aggregated request
  // ---------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] prev_reg;
  logic [NUM_IRQ-1:0] pending_reg;
  logic [NUM_IRQ-1:0] pending_next;
  logic               irq_reg;
  logic               irq_next;
  logic [NUM_IRQ-1:0] rise;

  assign rise = filt_reg & ~prev_reg;

  // Edge channels: clear is applied before OR-ing in the new edge, so a
  // simultaneous rise wins over clr_i. Level channels mirror the filtered
  // value and ignore clr_i. Switching level->edge therefore keeps whatever
  // pending value was last copied from the filter until it is cleared.
  assign pending_next = (mode_i  & ((pending_reg & ~clr_i) | rise))
                      | (~mode_i & filt_reg);

  // Uses the registered pending value, so irq_o lags pending_o by one edge
  // and mask changes take effect one edge later.
  assign irq_next = |(pending_reg & mask_i);

  always_ff @(posedge aclk) begin
    if (areset) begin
      filt_reg    <= '0;
      prev_reg    <= '0;
      pending_reg <= '0;
      irq_reg     <= 1'b0;
    end else begin
      filt_reg    <= filt_next;
      prev_reg    <= filt_reg;
      pending_reg <= pending_next;
      irq_reg     <= irq_next;
    end
  end

  assign sync_o    = sync_last;
  assign pending_o = pending_reg;
  assign irq_o     = irq_reg;

endmodule

// File: tb/tb_irq_sync_ctrl.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for irq_sync_ctrl.
// Main instance uses the default parameters (DEFAULT_LEVEL = 0); a second
// instance with DEFAULT_LEVEL = 1 covers the reset-value scenario.
// Expected latencies depend on whether IRQ_SYNC_FILTER_EN is defined:
// with the filter, f moves FILTER_LEN (3) edges after sync_o; without it,
// one edge after.
// -----------------------------------------------------------------------------
module tb_irq_sync_ctrl;

`ifdef IRQ_SYNC_FILTER_EN
  localparam int FL = 3;
  localparam bit FILT = 1'b1;
`else
  localparam int FL = 1;
  localparam bit FILT = 1'b0;
`endif

  logic       aclk;
  logic       areset;
  logic [7:0] irq_i;
  logic [7:0] polarity_i;
  logic [7:0] mode_i;
  logic [7:0] mask_i;
  logic [7:0] clr_i;
  logic [7:0] sync_o;
  logic [7:0] pending_o;
  logic       irq_o;

  // second instance (DEFAULT_LEVEL = 1), all lines held high, level mode
  logic [7:0] irq_b;
  logic [7:0] zero_b;
  logic [7:0] ones_b;
  logic [7:0] sync_b;
  logic [7:0] pending_b;
  logic       irq_ob;

  int checks;
  int passes;

  irq_sync_ctrl #(
    .NUM_IRQ(8), .SYNC_DEPTH(2), .DEFAULT_LEVEL(0), .FILTER_LEN(3)
  ) dut (
    .aclk(aclk), .areset(areset), .irq_i(irq_i), .polarity_i(polarity_i),
    .mode_i(mode_i), .mask_i(mask_i), .clr_i(clr_i), .sync_o(sync_o),
    .pending_o(pending_o), .irq_o(irq_o)
  );

  irq_sync_ctrl #(
    .NUM_IRQ(8), .SYNC_DEPTH(2), .DEFAULT_LEVEL(1), .FILTER_LEN(3)
  ) dut_dl1 (
    .aclk(aclk), .areset(areset), .irq_i(irq_b), .polarity_i(zero_b),
    .mode_i(zero_b), .mask_i(ones_b), .clr_i(zero_b), .sync_o(sync_b),
    .pending_o(pending_b), .irq_o(irq_ob)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    tick(3);
    checks++; if (sync_b !== 8'hFF) $display("FAIL rst_sync_dl1: got %h expected %h", sync_b, 8'hFF); else passes++;
    checks++; if (pending_b !== 8'h00) $display("FAIL rst_pend_dl1: got %h expected %h", pending_b, 8'h00); else passes++;
    checks++; if (irq_ob !== 1'b0) $display("FAIL rst_irq_dl1: got %b expected %b", irq_ob, 1'b0); else passes++;
    checks++; if (sync_o !== 8'h00) $display("FAIL rst_sync: got %h expected %h", sync_o, 8'h00); else passes++;
    checks++; if (pending_o !== 8'h00) $display("FAIL rst_pend: got %h expected %h", pending_o, 8'h00); else passes++;
    checks++; if (irq_o !== 1'b0) $display("FAIL rst_irq: got %b expected %b", irq_o, 1'b0); else passes++;
    areset = 1'b0;
    // sync chain already holds 1, so f moves FL edges after release
    tick(FL);
    checks++; if (pending_b !== 8'h00) $display("FAIL rst_lvl_early: got %h expected %h", pending_b, 8'h00); else passes++;
    tick(1);
    checks++; if (pending_b !== 8'hFF) $display("FAIL rst_lvl_pend: got %h expected %h", pending_b, 8'hFF); else passes++;
    tick(1);
    checks++; if (irq_ob !== 1'b1) $display("FAIL rst_lvl_irq: got %b expected %b", irq_ob, 1'b1); else passes++;
  endtask

  task automatic test_edge_clear();
    mode_i[0] = 1'b1;
    mask_i[0] = 1'b1;
    irq_i[0]  = 1'b1;
    tick(2 + FL);
    checks++; if (pending_o[0] !== 1'b0) $display("FAIL edge_pend_early: got %b expected %b", pending_o[0], 1'b0); else passes++;
    tick(1);
    checks++; if (pending_o[0] !== 1'b1) $display("FAIL edge_pend_set: got %b expected %b", pending_o[0], 1'b1); else passes++;
    checks++; if (irq_o !== 1'b0) $display("FAIL edge_irq_early: got %b expected %b", irq_o, 1'b0); else passes++;
    tick(1);
    checks++; if (irq_o !== 1'b1) $display("FAIL edge_irq_set: got %b expected %b", irq_o, 1'b1); else passes++;
    tick(2);
    clr_i[0] = 1'b1;
    tick(1);
    clr_i[0] = 1'b0;
    checks++; if (pending_o[0] !== 1'b0) $display("FAIL edge_clr_pend: got %b expected %b", pending_o[0], 1'b0); else passes++;
    checks++; if (irq_o !== 1'b1) $display("FAIL edge_clr_irq_lag: got %b expected %b", irq_o, 1'b1); else passes++;
    tick(1);
    checks++; if (irq_o !== 1'b0) $display("FAIL edge_clr_irq: got %b expected %b", irq_o, 1'b0); else passes++;
    tick(5);
    checks++; if (pending_o[0] !== 1'b0) $display("FAIL edge_no_reset: got %b expected %b", pending_o[0], 1'b0); else passes++;
    irq_i[0] = 1'b0;
    tick(FL + 4);
  endtask

  task automatic test_glitch();
    mode_i[3] = 1'b1;
    irq_i[3]  = 1'b1;
    tick(2);
    irq_i[3]  = 1'b0;
    tick(10);
    // filtered build rejects the 2-cycle pulse, unfiltered build latches it
    checks++; if (pending_o[3] !== !FILT) $display("FAIL glitch_2cyc: got %b expected %b", pending_o[3], !FILT); else passes++;
    clr_i[3] = 1'b1;
    tick(1);
    clr_i[3] = 1'b0;
    checks++; if (pending_o[3] !== 1'b0) $display("FAIL glitch_clr: got %b expected %b", pending_o[3], 1'b0); else passes++;
    irq_i[3] = 1'b1;
    tick(3);
    irq_i[3] = 1'b0;
    tick(10);
    checks++; if (pending_o[3] !== 1'b1) $display("FAIL glitch_3cyc: got %b expected %b", pending_o[3], 1'b1); else passes++;
    clr_i[3] = 1'b1;
    tick(1);
    clr_i[3] = 1'b0;
    checks++; if (pending_o[3] !== 1'b0) $display("FAIL glitch_clr2: got %b expected %b", pending_o[3], 1'b0); else passes++;
  endtask

  task automatic test_collision();
    mode_i[1] = 1'b1;
    irq_i[1]  = 1'b1;
    tick(2 + FL);
    checks++; if (pending_o[1] !== 1'b0) $display("FAIL coll_pre: got %b expected %b", pending_o[1], 1'b0); else passes++;
    // rise[1] is active for exactly the next edge; clear it at the same time
    clr_i[1] = 1'b1;
    tick(1);
    clr_i[1] = 1'b0;
    checks++; if (pending_o[1] !== 1'b1) $display("FAIL coll_set_wins: got %b expected %b", pending_o[1], 1'b1); else passes++;
    tick(2);
    checks++; if (pending_o[1] !== 1'b1) $display("FAIL coll_hold: got %b expected %b", pending_o[1], 1'b1); else passes++;
    clr_i[1] = 1'b1;
    tick(1);
    clr_i[1] = 1'b0;
    checks++; if (pending_o[1] !== 1'b0) $display("FAIL coll_clr: got %b expected %b", pending_o[1], 1'b0); else passes++;
    irq_i[1] = 1'b0;
    tick(FL + 4);
  endtask

  task automatic test_polarity_level_mask();
    mask_i = 8'h00;
    // bring ch5 to its idle-high state before switching it to active-low
    irq_i[5] = 1'b1;
    tick(3);
    polarity_i[5] = 1'b1;
    tick(FL + 6);
    checks++; if (pending_o[5] !== 1'b0) $display("FAIL pol_idle: got %b expected %b", pending_o[5], 1'b0); else passes++;
    irq_i[5] = 1'b0;
    tick(2 + FL);
    checks++; if (pending_o[5] !== 1'b0) $display("FAIL pol_lvl_early: got %b expected %b", pending_o[5], 1'b0); else passes++;
    tick(1);
    checks++; if (pending_o[5] !== 1'b1) $display("FAIL pol_lvl_set: got %b expected %b", pending_o[5], 1'b1); else passes++;
    tick(3);
    checks++; if (irq_o !== 1'b0) $display("FAIL mask_blocks: got %b expected %b", irq_o, 1'b0); else passes++;
    clr_i[5] = 1'b1;
    tick(1);
    clr_i[5] = 1'b0;
    checks++; if (pending_o[5] !== 1'b1) $display("FAIL lvl_clr_ignored: got %b expected %b", pending_o[5], 1'b1); else passes++;
    mask_i[5] = 1'b1;
    tick(1);
    checks++; if (irq_o !== 1'b1) $display("FAIL mask_enable: got %b expected %b", irq_o, 1'b1); else passes++;
    mask_i[5] = 1'b0;
    tick(1);
    checks++; if (irq_o !== 1'b0) $display("FAIL mask_disable: got %b expected %b", irq_o, 1'b0); else passes++;
    checks++; if (pending_o[5] !== 1'b1) $display("FAIL mask_keeps_pend: got %b expected %b", pending_o[5], 1'b1); else passes++;
    irq_i[5] = 1'b1;
    tick(2 + FL);
    checks++; if (pending_o[5] !== 1'b1) $display("FAIL pol_rel_early: got %b expected %b", pending_o[5], 1'b1); else passes++;
    tick(1);
    checks++; if (pending_o[5] !== 1'b0) $display("FAIL pol_rel: got %b expected %b", pending_o[5], 1'b0); else passes++;
    polarity_i[5] = 1'b0;
    irq_i[5] = 1'b0;
    tick(12);
  endtask

  task automatic test_mid_reset();
    mask_i = 8'h10;
    mode_i[4] = 1'b1;
    mode_i[2] = 1'b1;
    irq_i[4] = 1'b1;
    tick(3 + FL);
    checks++; if (pending_o !== 8'h10) $display("FAIL mrst_pend_pre: got %h expected %h", pending_o, 8'h10); else passes++;
    tick(1);
    checks++; if (irq_o !== 1'b1) $display("FAIL mrst_irq_pre: got %b expected %b", irq_o, 1'b1); else passes++;
    irq_i[2] = 1'b1;
    tick(3);
    checks++; if (pending_o[2] !== 1'b0) $display("FAIL mrst_ch2_pre: got %b expected %b", pending_o[2], 1'b0); else passes++;
    areset = 1'b1;
    tick(1);
    checks++; if (pending_o !== 8'h00) $display("FAIL mrst_pend: got %h expected %h", pending_o, 8'h00); else passes++;
    checks++; if (irq_o !== 1'b0) $display("FAIL mrst_irq: got %b expected %b", irq_o, 1'b0); else passes++;
    checks++; if (sync_o !== 8'h00) $display("FAIL mrst_sync: got %h expected %h", sync_o, 8'h00); else passes++;
    areset = 1'b0;
    irq_i = 8'h00;
    tick(8);
    checks++; if (pending_o !== 8'h00) $display("FAIL mrst_quiet: got %h expected %h", pending_o, 8'h00); else passes++;
    irq_i[2] = 1'b1;
    tick(3);
    irq_i[2] = 1'b0;
    tick(10);
    checks++; if (pending_o !== 8'h04) $display("FAIL mrst_new_pulse: got %h expected %h", pending_o, 8'h04); else passes++;
    checks++; if (irq_o !== 1'b0) $display("FAIL mrst_irq_masked: got %b expected %b", irq_o, 1'b0); else passes++;
  endtask

  initial begin
    checks     = 0;
    passes     = 0;
    areset     = 1'b1;
    irq_i      = 8'h00;
    polarity_i = 8'h00;
    mode_i     = 8'h00;
    mask_i     = 8'h00;
    clr_i      = 8'h00;
    irq_b      = 8'hFF;
    zero_b     = 8'h00;
    ones_b     = 8'hFF;

    test_reset();
    test_edge_clear();
    test_glitch();
    test_collision();
    test_polarity_level_mask();
    test_mid_reset();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "bench timeout");
  end

endmodule
